// File: rtl/dlf_exc_pkg.sv
// Shared definitions for the DLFloat exception flag path: flag indices,
// CSR operation encodings and the 5-bit flag vector type.
package dlf_exc_pkg;

  localparam int NUM_FLAGS = 5;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef logic [NUM_FLAGS-1:0] flag_vec_t;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // Value fflags takes from the CSR access alone, before new events merge in.
  function automatic flag_vec_t csr_base(flag_vec_t cur, csr_op_e op, flag_vec_t wd);
    flag_vec_t res;
    res = cur;
    case (op)
      CSR_WRITE: res = wd;
      CSR_SET:   res = cur | wd;
      CSR_CLEAR: res = cur & ~wd;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exc_sat_counter.sv
// Saturating event counter; clr reloads the counter with the current
// increment so an event coinciding with the clear is not lost.
module exc_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count_d = count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/exception_flag_csr.sv
// Sticky fflags CSR with per-lane sticky masks, per-flag event counters and
// a trap request for enabled exceptions, fed by exception_unit.
module exception_flag_csr
  import dlf_exc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_valid,
  input  logic [LANES-1:0]     invalid,
  input  logic [LANES-1:0]     div_by_zero,
  input  logic [LANES-1:0]     overflow,
  input  logic [LANES-1:0]     underflow,
  input  logic [LANES-1:0]     inexact,
  input  logic [1:0]           csr_op,
  input  logic [4:0]           csr_wdata,
  input  logic [4:0]           trap_en,
  input  logic                 irq_ack,
  input  logic                 cnt_clr,
  input  logic [2:0]           cnt_sel,
  output logic [4:0]           fflags,
  output logic [5*LANES-1:0]   lane_sticky,
  output logic                 irq,
  output logic [4:0]           irq_cause,
  output logic [CNT_W-1:0]     cnt_rdata
);

  logic [LANES-1:0]   lane_in [NUM_FLAGS];
  flag_vec_t          new_flags;
  flag_vec_t          base;
  flag_vec_t          lane_clr;
  flag_vec_t          hit;
  flag_vec_t          fflags_d;
  flag_vec_t          cause_d;
  logic               irq_d;
  logic [5*LANES-1:0] lane_d;
  logic [CNT_W-1:0]   cnt_q [NUM_FLAGS];

  always_comb begin
    lane_in[FLG_NV] = invalid;
    lane_in[FLG_DZ] = div_by_zero;
    lane_in[FLG_OF] = overflow;
    lane_in[FLG_UF] = underflow;
    lane_in[FLG_NX] = inexact;
  end

  always_comb begin
    new_flags = '0;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      new_flags[f] = flag_valid & (|lane_in[f]);
    end
  end

  assign base     = csr_base(fflags, csr_op_e'(csr_op), csr_wdata);
  assign fflags_d = base | new_flags;
  // Lane history is only dropped when the CSR access actually clears the flag.
  assign lane_clr = fflags & ~base;
  assign hit      = new_flags & trap_en;

  always_comb begin
    lane_d = lane_sticky;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      lane_d[f*LANES +: LANES] = (lane_sticky[f*LANES +: LANES] & {LANES{~lane_clr[f]}})
                               | (lane_in[f] & {LANES{flag_valid}});
    end
  end

  // An ack with a fresh enabled hit hands the new cause straight over
  // instead of dropping the request for a cycle.
  always_comb begin
    irq_d   = irq;
    cause_d = irq_cause;
    if (!irq) begin
      if (|hit) begin
        irq_d   = 1'b1;
        cause_d = hit;
      end
    end else if (!irq_ack) begin
      cause_d = irq_cause | hit;
    end else if (|hit) begin
      cause_d = hit;
    end else begin
      irq_d   = 1'b0;
      cause_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags      <= '0;
      lane_sticky <= '0;
      irq         <= 1'b0;
      irq_cause   <= '0;
    end else begin
      fflags      <= fflags_d;
      lane_sticky <= lane_d;
      irq         <= irq_d;
      irq_cause   <= cause_d;
    end
  end

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_cnt
    exc_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (new_flags[g]),
      .clr  (cnt_clr),
      .count(cnt_q[g])
    );
  end

  always_comb begin
    cnt_rdata = '0;
    case (cnt_sel)
      3'd0:    cnt_rdata = cnt_q[0];
      3'd1:    cnt_rdata = cnt_q[1];
      3'd2:    cnt_rdata = cnt_q[2];
      3'd3:    cnt_rdata = cnt_q[3];
      3'd4:    cnt_rdata = cnt_q[4];
      default: cnt_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_flag_csr.sv
// Scoreboard bench for exception_flag_csr: directed scenarios plus random
// traffic checked against a behavioural model of the flag/trap/counter rules.
module tb_exception_flag_csr;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag_valid = 1'b0;
  logic [4:0][3:0] lf = '0;
  logic [1:0] csr_op = 2'b00;
  logic [4:0] csr_wdata = '0;
  logic [4:0] trap_en = '0;
  logic irq_ack = 1'b0;
  logic cnt_clr = 1'b0;
  logic [2:0] cnt_sel = '0;
  logic [4:0] fflags;
  logic [5*LANES-1:0] lane_sticky;
  logic irq;
  logic [4:0] irq_cause;
  logic [CNT_W-1:0] cnt_rdata;

  exception_flag_csr #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flag_valid(flag_valid),
    .invalid(lf[4]), .div_by_zero(lf[3]), .overflow(lf[2]),
    .underflow(lf[1]), .inexact(lf[0]),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .trap_en(trap_en),
    .irq_ack(irq_ack), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
    .fflags(fflags), .lane_sticky(lane_sticky), .irq(irq),
    .irq_cause(irq_cause), .cnt_rdata(cnt_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ff;
    logic [19:0] ls;
    logic        irq;
    logic [4:0]  cause;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // reference state
  logic [4:0] m_ff;
  logic [3:0] m_lane [5];
  int         m_cnt [5];
  logic       m_irq;
  logic [4:0] m_cause;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_ff = '0;
    m_irq = 1'b0;
    m_cause = '0;
    for (int f = 0; f < 5; f++) begin
      m_lane[f] = '0;
      m_cnt[f] = 0;
    end
  endfunction

  function automatic exp_t model_view(input logic [2:0] sel);
    exp_t e;
    e.ff = m_ff;
    for (int f = 0; f < 5; f++) e.ls[f*4 +: 4] = m_lane[f];
    e.irq = m_irq;
    e.cause = m_cause;
    e.cnt = (sel < 5) ? 4'(m_cnt[sel]) : 4'd0;
    return e;
  endfunction

  task automatic step(input logic r, input logic fv, input logic [4:0][3:0] l,
                      input logic [1:0] op, input logic [4:0] wd, input logic [4:0] te,
                      input logic ack, input logic clr, input logic [2:0] sel);
    logic [4:0] nw;
    logic [4:0] base;
    logic [4:0] hit;
    @(negedge clk);
    rst = r; flag_valid = fv; lf = l; csr_op = op; csr_wdata = wd;
    trap_en = te; irq_ack = ack; cnt_clr = clr; cnt_sel = sel;
    if (r) begin
      model_reset();
    end else begin
      for (int f = 0; f < 5; f++) nw[f] = fv && (l[f] != 4'd0);
      case (op)
        2'b01:   base = wd;
        2'b10:   base = m_ff | wd;
        2'b11:   base = m_ff & ~wd;
        default: base = m_ff;
      endcase
      for (int f = 0; f < 5; f++) begin
        if (m_ff[f] && !base[f]) m_lane[f] = '0;
        if (fv) m_lane[f] = m_lane[f] | l[f];
        if (clr) m_cnt[f] = nw[f] ? 1 : 0;
        else if (nw[f] && m_cnt[f] < CMAX) m_cnt[f] = m_cnt[f] + 1;
      end
      hit = nw & te;
      if (!m_irq) begin
        if (hit != 0) begin m_irq = 1'b1; m_cause = hit; end
      end else if (!ack) begin
        m_cause = m_cause | hit;
      end else if (hit != 0) begin
        m_cause = hit;
      end else begin
        m_irq = 1'b0; m_cause = '0;
      end
      m_ff = base | nw;
    end
    exp_q.push_back(model_view(sel));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0][3:0] one_flag(input int f, input logic [3:0] v);
    logic [4:0][3:0] l;
    l = '0;
    l[f] = v;
    return l;
  endfunction

  // monitor: every clocked result is compared against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb_fflags", 32'(fflags), 32'(e.ff));
        cmp("sb_lane_sticky", 32'(lane_sticky), 32'(e.ls));
        cmp("sb_irq", 32'(irq), 32'(e.irq));
        cmp("sb_irq_cause", 32'(irq_cause), 32'(e.cause));
        cmp("sb_cnt_rdata", 32'(cnt_rdata), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [4:0][3:0] l;
    logic [1:0] op;
    model_reset();
    step(1, 0, '0, 2'b00, 5'd0, 5'd0, 0, 0, 3'd0);
    step(1, 0, '0, 2'b00, 5'd0, 5'd0, 0, 0, 3'd2);
    settle();
    cmp("reset_fflags", 32'(fflags), 32'd0);
    cmp("reset_irq", 32'(irq), 32'd0);
    cmp("reset_cnt", 32'(cnt_rdata), 32'd0);

    // single overflow event on lane 2
    step(0, 1, one_flag(2, 4'b0100), 2'b00, 5'd0, 5'd0, 0, 0, 3'd2);
    settle();
    cmp("of_fflags", 32'(fflags), 32'h04);
    cmp("of_lane", 32'(lane_sticky[8 +: 4]), 32'h4);
    cmp("of_cnt", 32'(cnt_rdata), 32'd1);
    cmp("of_irq", 32'(irq), 32'd0);

    // clear of NX coinciding with a new NX event
    step(0, 1, one_flag(0, 4'b1000), 2'b00, 5'd0, 5'd0, 0, 0, 3'd0);
    step(0, 0, '0, 2'b01, 5'b10001, 5'd0, 0, 0, 3'd0);
    step(0, 1, one_flag(0, 4'b0001), 2'b11, 5'b00001, 5'd0, 0, 0, 3'd0);
    settle();
    cmp("clr_fflags", 32'(fflags), 32'h11);
    cmp("clr_nx_lane", 32'(lane_sticky[0 +: 4]), 32'h1);

    // trap raise, accumulate-disabled, ack
    step(0, 1, one_flag(4, 4'b0010), 2'b00, 5'd0, 5'b10000, 0, 0, 3'd4);
    settle();
    cmp("trap_irq", 32'(irq), 32'd1);
    cmp("trap_cause", 32'(irq_cause), 32'h10);
    step(0, 1, one_flag(3, 4'b0001), 2'b00, 5'd0, 5'b10000, 0, 0, 3'd3);
    settle();
    cmp("trap_dz_cause", 32'(irq_cause), 32'h10);
    step(0, 0, '0, 2'b00, 5'd0, 5'b10000, 1, 0, 3'd3);
    settle();
    cmp("ack_irq", 32'(irq), 32'd0);
    cmp("ack_cause", 32'(irq_cause), 32'd0);

    // ack coinciding with a new enabled event
    step(0, 1, one_flag(4, 4'b0001), 2'b00, 5'd0, 5'b10000, 0, 0, 3'd4);
    step(0, 1, one_flag(4, 4'b1000), 2'b00, 5'd0, 5'b10000, 1, 0, 3'd4);
    settle();
    cmp("ackhit_irq", 32'(irq), 32'd1);
    cmp("ackhit_cause", 32'(irq_cause), 32'h10);
    step(0, 0, '0, 2'b00, 5'd0, 5'd0, 1, 0, 3'd4);

    // counter saturation and clear-with-event
    for (int i = 0; i < 20; i++)
      step(0, 1, one_flag(1, 4'b0001), 2'b00, 5'd0, 5'd0, 0, 0, 3'd1);
    settle();
    cmp("uf_sat", 32'(cnt_rdata), 32'd15);
    step(0, 1, one_flag(1, 4'b0010), 2'b00, 5'd0, 5'd0, 0, 1, 3'd1);
    settle();
    cmp("uf_clr_inc", 32'(cnt_rdata), 32'd1);
    step(0, 0, '0, 2'b00, 5'd0, 5'd0, 0, 0, 3'd6);
    settle();
    cmp("sel6_zero", 32'(cnt_rdata), 32'd0);

    // all-zero flags on a retiring op change nothing
    step(0, 1, '0, 2'b00, 5'd0, 5'b11111, 0, 0, 3'd1);

    // asynchronous reset between edges
    l = '1;
    step(0, 1, l, 2'b00, 5'd0, 5'b11111, 0, 0, 3'd1);
    settle();
    cmp("pre_rst_fflags", 32'(fflags), 32'h1f);
    cmp("pre_rst_irq", 32'(irq), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    cmp("arst_fflags", 32'(fflags), 32'd0);
    cmp("arst_lane", 32'(lane_sticky), 32'd0);
    cmp("arst_irq", 32'(irq), 32'd0);
    cmp("arst_cause", 32'(irq_cause), 32'd0);
    cmp("arst_cnt", 32'(cnt_rdata), 32'd0);
    step(1, 0, '0, 2'b00, 5'd0, 5'd0, 0, 0, 3'd1);
    step(0, 1, one_flag(1, 4'b0100), 2'b00, 5'd0, 5'd0, 0, 0, 3'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int f = 0; f < 5; f++)
        l[f] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), l, op,
           5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    cmp("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
